// File: rtl/ddfs_ftw_sweep_if.sv
// Configuration handshake and tuning-word output bundle for the DDFS sweep controller.
interface ddfs_ftw_sweep_if #(
  parameter int unsigned FTW_W   = 8,
  parameter int unsigned DWELL_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [FTW_W-1:0]   cfg_start_ftw;
  logic [FTW_W-1:0]   cfg_stop_ftw;
  logic [FTW_W-1:0]   cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic               cfg_mode;
  logic               abort;
  logic [FTW_W-1:0]   q_ftw;
  logic               ftw_valid;
  logic               busy;
  logic               done;

  modport master (
    output cfg_valid, cfg_start_ftw, cfg_stop_ftw, cfg_step, cfg_dwell, cfg_mode, abort,
    input  cfg_ready, q_ftw, ftw_valid, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_start_ftw, cfg_stop_ftw, cfg_step, cfg_dwell, cfg_mode, abort,
    output cfg_ready, q_ftw, ftw_valid, busy, done
  );
endinterface

// File: rtl/ddfs_ftw_sweep.sv
// Frequency-sweep controller: single or continuous triangle sweep of the DDFS tuning word.
module ddfs_ftw_sweep #(
  parameter int unsigned FTW_W   = 8,
  parameter int unsigned DWELL_W = 16
) (
  input logic             clk,
  input logic             reset,
  ddfs_ftw_sweep_if.slave bus
);

  typedef enum logic {IDLE, DWELL} state_t;

  state_t             state, state_d;
  logic [FTW_W-1:0]   q_ftw, q_ftw_d;
  logic               ftw_valid, ftw_valid_d;
  logic               busy, busy_d;
  logic               done, done_d;
  logic [DWELL_W-1:0] cnt, cnt_d;
  logic [DWELL_W-1:0] dwell, dwell_d;
  logic [FTW_W-1:0]   start_ftw, start_ftw_d;
  logic [FTW_W-1:0]   stop_ftw, stop_ftw_d;
  logic [FTW_W-1:0]   step, step_d;
  logic               mode, mode_d;
  logic [FTW_W-1:0]   target, target_d;
  logic [FTW_W-1:0]   next_target;

  // One step from cur toward tgt, clamped at tgt; the sum is one bit wider so it cannot wrap.
  function automatic logic [FTW_W-1:0] step_toward(input logic [FTW_W-1:0] cur,
                                                   input logic [FTW_W-1:0] tgt,
                                                   input logic [FTW_W-1:0] stp);
    logic [FTW_W:0]   sum;
    logic [FTW_W-1:0] diff;
    sum  = {1'b0, cur} + {1'b0, stp};
    diff = cur - tgt;
    if (tgt > cur) begin
      return (sum >= {1'b0, tgt}) ? tgt : sum[FTW_W-1:0];
    end
    return (diff <= stp) ? tgt : cur - stp;
  endfunction

  assign bus.cfg_ready = (state == IDLE) && !reset;
  assign bus.q_ftw     = q_ftw;
  assign bus.ftw_valid = ftw_valid;
  assign bus.busy      = busy;
  assign bus.done      = done;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      q_ftw     <= '0;
      ftw_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cnt       <= '0;
      dwell     <= '0;
      start_ftw <= '0;
      stop_ftw  <= '0;
      step      <= '0;
      mode      <= 1'b0;
      target    <= '0;
    end else begin
      state     <= state_d;
      q_ftw     <= q_ftw_d;
      ftw_valid <= ftw_valid_d;
      busy      <= busy_d;
      done      <= done_d;
      cnt       <= cnt_d;
      dwell     <= dwell_d;
      start_ftw <= start_ftw_d;
      stop_ftw  <= stop_ftw_d;
      step      <= step_d;
      mode      <= mode_d;
      target    <= target_d;
    end
  end

  // Next-state logic: config capture, dwell countdown, step/turnaround/completion and abort.
  always_comb begin
    state_d     = state;
    q_ftw_d     = q_ftw;
    ftw_valid_d = 1'b0;
    busy_d      = busy;
    done_d      = 1'b0;
    cnt_d       = cnt;
    dwell_d     = dwell;
    start_ftw_d = start_ftw;
    stop_ftw_d  = stop_ftw;
    step_d      = step;
    mode_d      = mode;
    target_d    = target;
    next_target = (target == stop_ftw) ? start_ftw : stop_ftw;

    case (state)
      IDLE: begin
        if (bus.cfg_valid) begin
          start_ftw_d = bus.cfg_start_ftw;
          stop_ftw_d  = bus.cfg_stop_ftw;
          step_d      = (bus.cfg_step == '0) ? FTW_W'(1) : bus.cfg_step;
          dwell_d     = bus.cfg_dwell;
          mode_d      = bus.cfg_mode;
          target_d    = bus.cfg_stop_ftw;
          q_ftw_d     = bus.cfg_start_ftw;
          cnt_d       = bus.cfg_dwell;
          ftw_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = DWELL;
        end
      end
      DWELL: begin
        if (bus.abort) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - DWELL_W'(1);
        end else if (q_ftw != target) begin
          q_ftw_d     = step_toward(q_ftw, target, step);
          ftw_valid_d = 1'b1;
          cnt_d       = dwell;
        end else if (!mode) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          // Triangle turnaround; with start == stop the word simply holds.
          target_d = next_target;
          cnt_d    = dwell;
          if (next_target != q_ftw) begin
            q_ftw_d     = step_toward(q_ftw, next_target, step);
            ftw_valid_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ddfs_ftw_sweep.sv
// Self-checking bench for ddfs_ftw_sweep against a sequence-level sweep model.
module tb_ddfs_ftw_sweep;

  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  ddfs_ftw_sweep_if #(.FTW_W(8), .DWELL_W(16)) bus ();

  ddfs_ftw_sweep #(.FTW_W(8), .DWELL_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one configuration and check every output cycle against the expected value list.
  // abort_k: cycle index after which abort is raised (-1 none); max_cyc: 0 = run to done.
  task automatic run_sweep(input int st, input int sp, input int stp, input int dw, input int md,
                           input int abort_k, input int max_cyc, input bit hold_valid,
                           input bit abort_acc, input string name);
    int vals[$];
    int hold, s, v, tgt, ncyc, idx, e_q;
    bit e_v, e_b, e_d;
    s    = (stp == 0) ? 1 : stp;
    hold = dw + 1;
    v    = st;
    tgt  = sp;
    vals.push_back(v);
    if (md == 0) begin
      while (v != tgt) begin
        v = (tgt > v) ? ((v + s >= tgt) ? tgt : v + s) : ((v - tgt <= s) ? tgt : v - s);
        vals.push_back(v);
      end
      ncyc = vals.size() * hold + 1;
      if (max_cyc > 0 && max_cyc < ncyc) ncyc = max_cyc;
    end else begin
      while (vals.size() < max_cyc / hold + 2) begin
        if (v == tgt) tgt = (tgt == sp) ? st : sp;
        if (v != tgt)
          v = (tgt > v) ? ((v + s >= tgt) ? tgt : v + s) : ((v - tgt <= s) ? tgt : v - s);
        vals.push_back(v);
      end
      ncyc = max_cyc;
    end

    bus.cfg_start_ftw = 8'(st);
    bus.cfg_stop_ftw  = 8'(sp);
    bus.cfg_step      = 8'(stp);
    bus.cfg_dwell     = 16'(dw);
    bus.cfg_mode      = md[0];
    bus.cfg_valid     = 1'b1;
    bus.abort         = abort_acc;
    total++;
    if (bus.cfg_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s accept: cfg_ready=%b want 1", name, bus.cfg_ready);
    end
    tick();
    bus.abort = 1'b0;
    if (!hold_valid) bus.cfg_valid = 1'b0;
    else begin
      bus.cfg_start_ftw = 8'($urandom);
      bus.cfg_stop_ftw  = 8'($urandom);
      bus.cfg_step      = 8'($urandom);
      bus.cfg_dwell     = 16'($urandom_range(0, 3));
      bus.cfg_mode      = 1'($urandom);
    end

    for (int k = 0; k < ncyc; k++) begin
      idx = k / hold;
      if (md != 0 || k < vals.size() * hold) begin
        e_q = vals[idx];
        e_v = (k % hold == 0) && (idx == 0 || vals[idx] != vals[idx-1]);
        e_b = 1'b1;
        e_d = 1'b0;
      end else begin
        e_q = vals[vals.size()-1];
        e_v = 1'b0;
        e_b = 1'b0;
        e_d = (k == vals.size() * hold);
      end
      total += 5;
      if (bus.q_ftw !== 8'(e_q)) begin
        bad++;
        $display("FAIL %s k=%0d q_ftw=%0d want %0d", name, k, bus.q_ftw, e_q);
      end
      if (bus.ftw_valid !== e_v) begin
        bad++;
        $display("FAIL %s k=%0d ftw_valid=%b want %b", name, k, bus.ftw_valid, e_v);
      end
      if (bus.busy !== e_b) begin
        bad++;
        $display("FAIL %s k=%0d busy=%b want %b", name, k, bus.busy, e_b);
      end
      if (bus.done !== e_d) begin
        bad++;
        $display("FAIL %s k=%0d done=%b want %b", name, k, bus.done, e_d);
      end
      if (bus.cfg_ready !== !e_b) begin
        bad++;
        $display("FAIL %s k=%0d cfg_ready=%b want %b", name, k, bus.cfg_ready, !e_b);
      end
      if (k == abort_k) begin
        bus.abort = 1'b1;
        tick();
        bus.abort     = 1'b0;
        bus.cfg_valid = 1'b0;
        total += 5;
        if (bus.q_ftw !== 8'(e_q)) begin
          bad++;
          $display("FAIL %s abort q_ftw=%0d want %0d", name, bus.q_ftw, e_q);
        end
        if (bus.ftw_valid !== 1'b0) begin
          bad++;
          $display("FAIL %s abort ftw_valid=%b want 0", name, bus.ftw_valid);
        end
        if (bus.busy !== 1'b0) begin
          bad++;
          $display("FAIL %s abort busy=%b want 0", name, bus.busy);
        end
        if (bus.done !== 1'b0) begin
          bad++;
          $display("FAIL %s abort done=%b want 0", name, bus.done);
        end
        if (bus.cfg_ready !== 1'b1) begin
          bad++;
          $display("FAIL %s abort cfg_ready=%b want 1", name, bus.cfg_ready);
        end
        break;
      end
      if (k != ncyc - 1) tick();
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset         = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.abort     = 1'b0;
    bus.cfg_start_ftw = '0;
    bus.cfg_stop_ftw  = '0;
    bus.cfg_step      = '0;
    bus.cfg_dwell     = '0;
    bus.cfg_mode      = 1'b0;
    tick();
    tick();
    total += 5;
    if (bus.q_ftw !== 8'd0) begin bad++; $display("FAIL reset q_ftw=%0d want 0", bus.q_ftw); end
    if (bus.ftw_valid !== 1'b0) begin bad++; $display("FAIL reset ftw_valid=%b want 0", bus.ftw_valid); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy=%b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done=%b want 0", bus.done); end
    if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL reset cfg_ready=%b want 0", bus.cfg_ready); end
    reset = 1'b0;
    #1;
    total++;
    if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_release cfg_ready=%b want 1", bus.cfg_ready); end
  endtask

  task automatic test_single_up();
    run_sweep(10, 20, 3, 2, 0, -1, 0, 1'b0, 1'b0, "single_up");
    tick();
  endtask

  task automatic test_down_clamp();
    run_sweep(200, 190, 4, 0, 0, -1, 0, 1'b0, 1'b0, "down_clamp");
    tick();
  endtask

  task automatic test_overflow();
    run_sweep(250, 255, 10, 1, 0, -1, 0, 1'b0, 1'b0, "overflow");
    tick();
  endtask

  task automatic test_triangle_abort();
    // Values 0,4,8,4: abort while on the descending 4.
    run_sweep(0, 8, 4, 0, 1, 3, 12, 1'b0, 1'b0, "triangle");
    tick();
  endtask

  task automatic test_handshake();
    run_sweep(40, 60, 7, 1, 0, -1, 0, 1'b1, 1'b0, "valid_held");
    tick();
    run_sweep(5, 9, 0, 1, 0, -1, 0, 1'b0, 1'b0, "step_zero");
    tick();
    run_sweep(30, 20, 5, 1, 0, -1, 0, 1'b0, 1'b1, "abort_in_idle");
    tick();
    run_sweep(77, 77, 3, 1, 1, 9, 10, 1'b0, 1'b0, "tri_equal");
    tick();
  endtask

  task automatic test_back_to_back();
    run_sweep(1, 7, 2, 1, 0, -1, 0, 1'b0, 1'b0, "b2b_a");
    run_sweep(100, 90, 3, 0, 0, -1, 0, 1'b0, 1'b0, "b2b_b");
    run_sweep(3, 3, 1, 2, 0, -1, 0, 1'b0, 1'b0, "b2b_c");
    tick();
  endtask

  task automatic test_random();
    int st, sp, stp, dw, md, ak;
    for (int i = 0; i < 24; i++) begin
      st  = int'($urandom_range(0, 255));
      sp  = int'($urandom_range(0, 255));
      stp = int'($urandom_range(0, 63));
      dw  = int'($urandom_range(0, 3));
      md  = int'($urandom_range(0, 1));
      if (md == 1) begin
        ak = int'($urandom_range(0, 59));
        run_sweep(st, sp, stp, dw, md, ak, 60, 1'($urandom), 1'b0, "rand_tri");
      end else begin
        ak = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
        run_sweep(st, sp, stp, dw, md, ak, 0, 1'($urandom), 1'b0, "rand_single");
      end
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  task automatic test_reset_mid();
    run_sweep(10, 100, 1, 3, 0, -1, 7, 1'b0, 1'b0, "pre_reset");
    reset = 1'b1;
    tick();
    total += 5;
    if (bus.q_ftw !== 8'd0) begin bad++; $display("FAIL mid_reset q_ftw=%0d want 0", bus.q_ftw); end
    if (bus.ftw_valid !== 1'b0) begin bad++; $display("FAIL mid_reset ftw_valid=%b want 0", bus.ftw_valid); end
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL mid_reset busy=%b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin bad++; $display("FAIL mid_reset done=%b want 0", bus.done); end
    if (bus.cfg_ready !== 1'b0) begin bad++; $display("FAIL mid_reset cfg_ready=%b want 0", bus.cfg_ready); end
    reset = 1'b0;
    #1;
    total++;
    if (bus.cfg_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_release cfg_ready=%b want 1", bus.cfg_ready); end
    tick();
    total += 2;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL post_reset busy=%b want 0", bus.busy); end
    if (bus.q_ftw !== 8'd0) begin bad++; $display("FAIL post_reset q_ftw=%0d want 0", bus.q_ftw); end
    run_sweep(50, 45, 2, 0, 0, -1, 0, 1'b0, 1'b0, "after_reset");
    tick();
  endtask

  initial begin
    test_reset();
    test_single_up();
    test_down_clamp();
    test_overflow();
    test_triangle_abort();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ddfs_ftw_sweep.md
# ddfs_ftw_sweep

Frequency-sweep controller directly upstream of the I/Q DDFS core. It generates the 8-bit frequency tuning word `q_ftw` that drives the DDFS phase accumulator. A configuration handshake starts a single or continuous triangle sweep, with a programmable step and a programmable dwell time per frequency. The sweep can be aborted at any time.

## Interface

- `FTW_W`, 8, tuning-word width (must match the DDFS `q_ftw` width)
- `DWELL_W`, 16, dwell counter width

- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `cfg_valid`  in  1  configuration offered
- `cfg_ready`  out  1  configuration accepted when high with `cfg_valid`
- `cfg_start_ftw`  in  FTW_W  first tuning word
- `cfg_stop_ftw`  in  FTW_W  end tuning word
- `cfg_step`  in  FTW_W  step magnitude; 0 is treated as 1
- `cfg_dwell`  in  DWELL_W  each word is held `cfg_dwell`+1 cycles
- `cfg_mode`  in  1  0 = single sweep, 1 = continuous triangle
- `abort`  in  1  terminate the sweep
- `q_ftw`  out  FTW_W  registered tuning word to the DDFS
- `ftw_valid`  out  1  one-cycle pulse whenever `q_ftw` takes a new sweep value
- `busy`  out  1  sweep in progress
- `done`  out  1  one-cycle pulse at normal completion of a single sweep

## Operation

- States:
  - IDLE: `cfg_ready`=1.
  - DWELL: hold `q_ftw`, count down.
  - STEP: internal single-edge transition folded into the dwell expiry; no extra cycle.
- Config fields are latched on `cfg_valid && cfg_ready`. Inputs are ignored at all other times, including `cfg_valid` while busy.
- Direction at start: up if `stop` >= `start`, else down. The target is initially `stop`.
- Dwell expiry, when `q_ftw` != target:
  - Up: compute the 9-bit sum `q_ftw`+step. If sum >= target, load target; else load sum.
  - Down: if `q_ftw`-target <= step, load target; else load `q_ftw`-step.
  - There is no wrap-around.
- Dwell expiry, when `q_ftw` == target:
  - Mode 0: go to IDLE and pulse `done`.
  - Mode 1: swap the target between start and stop, reverse direction, and take the first step toward the new target on the same edge.
  - Mode 1 with start == stop: hold `q_ftw` indefinitely; `ftw_valid` does not re-pulse.
- Abort, in DWELL: the next edge goes to IDLE. `q_ftw` holds its current value; no `done` pulse; `ftw_valid` stays 0.
  - Abort has priority over a step on the same edge.
  - Abort is ignored in IDLE; a simultaneous `cfg_valid` is still accepted.
- `q_ftw` holds its last value while IDLE. The DDFS keeps running at that frequency.
- Reset values: `q_ftw`=0, `ftw_valid`=0, `busy`=0, `done`=0, state IDLE.
  - `cfg_ready` is 0 while `reset` is high and 1 on the first cycle after.
  - Reset mid-sweep discards all configuration.

## Timing

- Acceptance at edge N:
  - Edge N+1: `q_ftw`=start, `ftw_valid`=1 for one cycle, `busy`=1, `cfg_ready`=0.
- Each value is held exactly D+1 cycles, where D = `cfg_dwell`. The next value registers D+1 edges after the previous one, with `ftw_valid` pulsing on that edge.
- Completion: at the edge ending the dwell of the final (stop) value:
  - `busy`=0, `done`=1 for one cycle, `cfg_ready`=1.
  - A new configuration may be accepted in that same `done` cycle.
- Single sweep of K values: completion edge = N+1+K·(D+1).
- Abort sampled high at edge M: `busy`=0 and `cfg_ready`=1 after edge M.
- All outputs are registered except `cfg_ready`, which decodes the state register.

## Test plan

- **Single up sweep.** start=10, stop=20, step=3, dwell=2, mode 0.
  - `q_ftw` sequence 10,13,16,19,20, each held 3 cycles.
  - Five `ftw_valid` pulses.
  - `done` 15 cycles after the first value.
- **Down sweep with clamp.** start=200, stop=190, step=4, dwell=0.
  - Sequence 200,196,192,190, one cycle each, then `done`.
- **Overflow guard.** start=250, stop=255, step=10.
  - Sequence 250,255; never wraps to 4.
- **Triangle.** start=0, stop=8, step=4, dwell=0, mode 1.
  - Sequence 0,4,8,4,0,4,8,…; `done` never asserts.
  - Abort on value 4 (descending): IDLE next cycle, `q_ftw` stays 4, no `done`.
- **Handshake.**
  - `cfg_valid` held high during a sweep is ignored.
  - A new config offered in the `done` cycle is accepted; its start appears on the next edge.
  - step=0 behaves as step=1.
- **Reset mid-sweep.** Assert `reset` during a dwell.
  - Next cycle: `q_ftw`=0 and all flags 0.
  - `cfg_ready` rises the cycle after `reset` drops.
